msrv_store_ctrl: RTL and testbench
==================================

MSRV_STORE_CTRL -- requirements
Module: msrv_store_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; legal values are 32 and 64.
REQ-002 SHALL have localparam NB = XLEN/8, meaning the number of byte lanes.
REQ-003 SHALL have port ms_riscv32_mp_clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ms_riscv32_mp_rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port st_valid_in, input, 1 bit: the core presents a store.
REQ-006 SHALL have port st_ready_out, output, 1 bit: the block accepts a store this cycle.
REQ-007 SHALL have port funct3_in, input, 3 bits: store size; bits [1:0] 00=SB, 01=SH, 10=SW, 11=SD; bit 2 is ignored.
REQ-008 SHALL have port iadder_in, input, XLEN bits: byte address of the store.
REQ-009 SHALL have port rs2_in, input, XLEN bits: store data, right-aligned.
REQ-010 SHALL have port ms_riscv32_mp_dmaddr_out, output, XLEN bits: lane-aligned bus address.
REQ-011 SHALL have port ms_riscv32_mp_dmdata_out, output, XLEN bits: lane-positioned write data.
REQ-012 SHALL have port ms_riscv32_mp_dmwr_mask_out, output, NB bits: byte-enable mask.
REQ-013 SHALL have port ms_riscv32_mp_dmwr_req_out, output, 1 bit: bus write request.
REQ-014 SHALL have port ms_riscv32_mp_dmwr_ack_in, input, 1 bit: the bus accepts the current beat.
REQ-015 SHALL have port st_done_out, output, 1 bit: one-cycle pulse when a store has completed.
REQ-016 SHALL have port st_exc_out, output, 1 bit: one-cycle pulse when a store is rejected.

Function
REQ-017 SHALL use states IDLE, BEAT0, BEAT1 and DONE; st_ready_out is 1 only in IDLE.
REQ-018 SHALL, on a cycle where st_valid_in and st_ready_out are both 1, register funct3, address and data, and assert dmwr_req_out in the next cycle (latency 1).
REQ-019 SHALL drive dmaddr_out = beat address with the low log2(NB) bits cleared.
REQ-020 SHALL drive dmwr_mask_out = size mask shifted left by offset; size masks are 1, 3, F or FF; offset = addr mod NB.
REQ-021 SHALL drive dmdata_out = rs2 shifted left by 8*offset, with unused lanes forced to 0.
REQ-022 SHALL hold dmwr_req_out, dmaddr_out, dmdata_out and dmwr_mask_out stable until dmwr_ack_in is sampled 1; an ack in the first request cycle is legal.
REQ-023 SHALL treat dmwr_ack_in as don't-care while dmwr_req_out is 0.
REQ-024 SHALL complete as follows: on the final ack go to DONE, pulse st_done_out for one cycle, deassert dmwr_req_out, then return to IDLE; minimum store period is 3 cycles.
REQ-025 SHALL reject funct3[1:0]=11 when XLEN=32: no bus request, st_exc_out pulses in the cycle after acceptance, return to IDLE.
REQ-026 SHALL treat a store as misaligned when offset + size > NB; handling is per REQ-031/REQ-032.
REQ-027 SHALL treat aligned stores, and stores that are unaligned but fit in one lane word, as single-beat with no exception.
REQ-028 SHALL never pulse st_done_out and st_exc_out for the same store.
REQ-029 SHALL wrap the address modulo 2^XLEN when the second beat address overflows.

Reset
REQ-030 SHALL, while ms_riscv32_mp_rst_in is 0 (asynchronously, including mid-beat): state IDLE; dmwr_req_out, st_done_out and st_exc_out 0; dmaddr_out, dmdata_out and dmwr_mask_out 0; any in-flight store discarded. st_ready_out is 1 in the first cycle after release.

Configuration
REQ-031 SHALL, with macro MSRV_STORE_MISALIGN_SPLIT_EN defined, split a misaligned store into two beats:
- BEAT0: address aligned(addr), low portion of the data, mask bits offset..NB-1.
- BEAT1: address aligned(addr)+NB, remaining bytes in lanes 0 upward, mask holding the remaining low bits.
- Each beat has its own request/ack handshake.
- st_done_out pulses only after the BEAT1 ack.
REQ-032 SHALL, without MSRV_STORE_MISALIGN_SPLIT_EN, issue no bus request for a misaligned store, pulse st_exc_out in the cycle after acceptance, and never enter BEAT1.

Verification
REQ-033 SHALL be covered by: XLEN=32, SB to addr 0x103, rs2=0x000000AB, ack in first request cycle -> addr 0x100, data 0xAB000000, mask 1000, done pulses 2 cycles after acceptance.
REQ-034 SHALL be covered by: XLEN=32, SW to addr 0x200, data 0x11223344, ack delayed 3 cycles -> req, address, data and mask 1111 stable for 4 cycles; one done pulse.
REQ-035 SHALL be covered by: XLEN=32, SPLIT_EN defined, SW to addr 0x102, data 0xAABBCCDD -> beat0 0x100/0xCCDD0000/1100, beat1 0x104/0x0000AABB/0011, one done pulse.
REQ-036 SHALL be covered by: same stimulus as REQ-035 with SPLIT_EN undefined -> no request, st_exc_out=1 for one cycle, st_ready_out=1 in the following cycle.
REQ-037 SHALL be covered by: XLEN=64, SD to 0x8, data 0x0102030405060708 -> mask FF, data unshifted; XLEN=32 SD -> exc pulse and no request.
REQ-038 SHALL be covered by: reset asserted while req is high in BEAT0 -> req falls without waiting for a clock edge; after release ready=1 and no done pulse.

Source files
------------

// File: rtl/msrv_store_ctrl_if.sv
// Store-controller data-memory write bus.
// The master (store controller) drives address, data, byte mask and request.
// The slave (memory) returns the beat acknowledge.
interface msrv_store_ctrl_if #(
   parameter int unsigned XLEN = 32
) ();
   localparam int unsigned NB = XLEN / 8;

   logic [XLEN-1:0] ms_riscv32_mp_dmaddr_out;
   logic [XLEN-1:0] ms_riscv32_mp_dmdata_out;
   logic [NB-1:0]   ms_riscv32_mp_dmwr_mask_out;
   logic            ms_riscv32_mp_dmwr_req_out;
   logic            ms_riscv32_mp_dmwr_ack_in;

   modport master (
      output ms_riscv32_mp_dmaddr_out,
      output ms_riscv32_mp_dmdata_out,
      output ms_riscv32_mp_dmwr_mask_out,
      output ms_riscv32_mp_dmwr_req_out,
      input  ms_riscv32_mp_dmwr_ack_in
   );

   modport slave (
      input  ms_riscv32_mp_dmaddr_out,
      input  ms_riscv32_mp_dmdata_out,
      input  ms_riscv32_mp_dmwr_mask_out,
      input  ms_riscv32_mp_dmwr_req_out,
      output ms_riscv32_mp_dmwr_ack_in
   );
endinterface

// File: rtl/msrv_store_ctrl.sv
// Store controller: accepts one store from the core, positions data and byte
// mask onto the data-memory lanes and runs the bus request/ack handshake.
// Optional feature macro: MSRV_STORE_MISALIGN_SPLIT_EN -- when defined, a store
// that crosses a lane-word boundary is issued as two beats; otherwise it is
// rejected with a one-cycle exception pulse.
module msrv_store_ctrl #(
   parameter int unsigned XLEN = 32
) (
   input  logic            ms_riscv32_mp_clk_in,
   input  logic            ms_riscv32_mp_rst_in,
   input  logic            st_valid_in,
   output logic            st_ready_out,
   input  logic [2:0]      funct3_in,
   input  logic [XLEN-1:0] iadder_in,
   input  logic [XLEN-1:0] rs2_in,
   output logic            st_done_out,
   output logic            st_exc_out,
   msrv_store_ctrl_if.master bus
);
   localparam int unsigned NB   = XLEN / 8;
   localparam int unsigned OffW = $clog2(NB);

`ifdef MSRV_STORE_MISALIGN_SPLIT_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;

   state_e          state_q, state_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [NB-1:0]   mask_q, mask_d;
   logic [XLEN-1:0] hi_data_q, hi_data_d;
   logic [NB-1:0]   hi_mask_q, hi_mask_d;
   logic            split_q, split_d;
   logic            done_q, done_d;
   logic            exc_q, exc_d;

   logic [OffW-1:0]   off;
   logic [7:0]        size_mask8;
   logic [3:0]        size_bytes;
   logic [NB-1:0]     size_mask;
   logic [XLEN-1:0]   rs2_m;
   logic [2*XLEN-1:0] wide_data;
   logic [2*NB-1:0]   wide_mask;
   logic [4:0]        off_sum;
   logic              misaligned;
   logic              illegal;
   logic [XLEN-1:0]   aligned_addr;

   assign off = iadder_in[OffW-1:0];

   // Decode store size into a byte-lane mask and a byte count.
   always_comb begin
      size_mask8 = 8'h01;
      size_bytes = 4'd1;
      unique case (funct3_in[1:0])
         2'b00: begin size_mask8 = 8'h01; size_bytes = 4'd1; end
         2'b01: begin size_mask8 = 8'h03; size_bytes = 4'd2; end
         2'b10: begin size_mask8 = 8'h0F; size_bytes = 4'd4; end
         2'b11: begin size_mask8 = 8'hFF; size_bytes = 4'd8; end
      endcase
   end

   assign size_mask = size_mask8[NB-1:0];

   // Zero the lanes the store size does not cover before positioning.
   always_comb begin
      rs2_m = '0;
      for (int i = 0; i < int'(NB); i++) begin
         rs2_m[8*i +: 8] = size_mask[i] ? rs2_in[8*i +: 8] : 8'h00;
      end
   end

   // Shifting into a double-width word yields both beats at once: the low half
   // is beat 0, the high half is what spills into the next lane word.
   assign wide_data    = {{XLEN{1'b0}}, rs2_m} << {off, 3'b000};
   assign wide_mask    = {{NB{1'b0}}, size_mask} << off;
   assign off_sum      = 5'(off) + 5'(size_bytes);
   assign misaligned   = off_sum > 5'(NB);
   assign illegal      = (XLEN == 32) && (funct3_in[1:0] == 2'b11);
   assign aligned_addr = {iadder_in[XLEN-1:OffW], {OffW{1'b0}}};

   // Next-state and registered-output logic for the store handshake.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      data_d    = data_q;
      mask_d    = mask_q;
      hi_data_d = hi_data_q;
      hi_mask_d = hi_mask_q;
      split_d   = split_q;
      done_d    = 1'b0;
      exc_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (st_valid_in) begin
               if (illegal || (misaligned && !SplitEn)) begin
                  state_d = StDone;
                  exc_d   = 1'b1;
               end else begin
                  state_d   = StBeat0;
                  req_d     = 1'b1;
                  addr_d    = aligned_addr;
                  data_d    = wide_data[XLEN-1:0];
                  mask_d    = wide_mask[NB-1:0];
                  hi_data_d = wide_data[2*XLEN-1:XLEN];
                  hi_mask_d = wide_mask[2*NB-1:NB];
                  split_d   = misaligned;
               end
            end
         end
         StBeat0: begin
            if (bus.ms_riscv32_mp_dmwr_ack_in) begin
               if (split_q) begin
                  // Second beat; the add wraps naturally at XLEN bits.
                  state_d = StBeat1;
                  addr_d  = addr_q + XLEN'(NB);
                  data_d  = hi_data_q;
                  mask_d  = hi_mask_q;
               end else begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  req_d   = 1'b0;
                  addr_d  = '0;
                  data_d  = '0;
                  mask_d  = '0;
               end
            end
         end
         StBeat1: begin
            if (bus.ms_riscv32_mp_dmwr_ack_in) begin
               state_d = StDone;
               done_d  = 1'b1;
               req_d   = 1'b0;
               addr_d  = '0;
               data_d  = '0;
               mask_d  = '0;
               split_d = 1'b0;
            end
         end
         StDone: begin
            state_d = StIdle;
            split_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         state_q   <= StIdle;
         req_q     <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         mask_q    <= '0;
         hi_data_q <= '0;
         hi_mask_q <= '0;
         split_q   <= 1'b0;
         done_q    <= 1'b0;
         exc_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         mask_q    <= mask_d;
         hi_data_q <= hi_data_d;
         hi_mask_q <= hi_mask_d;
         split_q   <= split_d;
         done_q    <= done_d;
         exc_q     <= exc_d;
      end
   end

   assign st_ready_out                    = (state_q == StIdle);
   assign st_done_out                     = done_q;
   assign st_exc_out                      = exc_q;
   assign bus.ms_riscv32_mp_dmaddr_out    = addr_q;
   assign bus.ms_riscv32_mp_dmdata_out    = data_q;
   assign bus.ms_riscv32_mp_dmwr_mask_out = mask_q;
   assign bus.ms_riscv32_mp_dmwr_req_out  = req_q;
endmodule

// File: tb/tb_msrv_store_ctrl.sv
// Directed bench for msrv_store_ctrl: a 32-bit instance covers byte/word,
// delayed-ack, misaligned, illegal-size and reset cases; a 64-bit instance
// covers the doubleword store.
module tb_msrv_store_ctrl;
   logic        clk;
   logic        rst_n;
   logic        v32, v64;
   logic [2:0]  f3_32, f3_64;
   logic [31:0] a32, d32;
   logic [63:0] a64, d64;
   logic        rdy32, rdy64, done32, done64, exc32, exc64;

   int checks = 0;
   int errors = 0;

   msrv_store_ctrl_if #(.XLEN(32)) bus32 ();
   msrv_store_ctrl_if #(.XLEN(64)) bus64 ();

   msrv_store_ctrl #(.XLEN(32)) dut32 (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst_n),
      .st_valid_in          (v32),
      .st_ready_out         (rdy32),
      .funct3_in            (f3_32),
      .iadder_in            (a32),
      .rs2_in               (d32),
      .st_done_out          (done32),
      .st_exc_out           (exc32),
      .bus                  (bus32.master)
   );

   msrv_store_ctrl #(.XLEN(64)) dut64 (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst_n),
      .st_valid_in          (v64),
      .st_ready_out         (rdy64),
      .funct3_in            (f3_64),
      .iadder_in            (a64),
      .rs2_in               (d64),
      .st_done_out          (done64),
      .st_exc_out           (exc64),
      .bus                  (bus64.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the 32-bit bus beat in one go.
   task automatic chk_beat32(input string tag, input logic req, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] mask);
      chk({tag, ".req"},  64'(bus32.ms_riscv32_mp_dmwr_req_out), 64'(req));
      chk({tag, ".addr"}, 64'(bus32.ms_riscv32_mp_dmaddr_out), 64'(addr));
      chk({tag, ".data"}, 64'(bus32.ms_riscv32_mp_dmdata_out), 64'(data));
      chk({tag, ".mask"}, 64'(bus32.ms_riscv32_mp_dmwr_mask_out), 64'(mask));
   endtask

   task automatic issue32(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
      f3_32 = f3;
      a32   = addr;
      d32   = data;
      v32   = 1'b1;
      tick();
      v32   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      v32 = 1'b0; v64 = 1'b0;
      f3_32 = '0; f3_64 = '0;
      a32 = '0; d32 = '0; a64 = '0; d64 = '0;
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      bus64.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      #1;
      chk_beat32("reset", 1'b0, 32'h0, 32'h0, 4'h0);
      chk("reset.done", 64'(done32), 64'd0);
      chk("reset.exc", 64'(exc32), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset.ready", 64'(rdy32), 64'd1);

      // SB to 0x103, ack in the first request cycle.
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b1;
      issue32(3'b000, 32'h0000_0103, 32'h0000_00AB);
      chk_beat32("sb", 1'b1, 32'h100, 32'hAB00_0000, 4'b1000);
      chk("sb.ready_busy", 64'(rdy32), 64'd0);
      tick();
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      chk("sb.done", 64'(done32), 64'd1);
      chk("sb.req_low", 64'(bus32.ms_riscv32_mp_dmwr_req_out), 64'd0);
      tick();
      chk("sb.done_pulse_end", 64'(done32), 64'd0);
      chk("sb.ready_back", 64'(rdy32), 64'd1);

      // SW to 0x200 with ack held off for 3 cycles: beat stays stable 4 cycles.
      issue32(3'b010, 32'h0000_0200, 32'h1122_3344);
      for (int i = 0; i < 4; i++) begin
         chk_beat32("sw_hold", 1'b1, 32'h200, 32'h1122_3344, 4'b1111);
         chk("sw_hold.no_done", 64'(done32), 64'd0);
         if (i == 3) bus32.ms_riscv32_mp_dmwr_ack_in = 1'b1;
         tick();
      end
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      chk("sw.done", 64'(done32), 64'd1);
      tick();
      chk("sw.single_done", 64'(done32), 64'd0);

      // SH at 0x101 fits in one lane word; upper rs2 bytes must be dropped.
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b1;
      issue32(3'b101, 32'h0000_0101, 32'hDEAD_1234);
      chk_beat32("sh_fit", 1'b1, 32'h100, 32'h0012_3400, 4'b0110);
      tick();
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      chk("sh_fit.done", 64'(done32), 64'd1);
      chk("sh_fit.exc", 64'(exc32), 64'd0);
      tick();

      // Misaligned SW to 0x102.
      issue32(3'b010, 32'h0000_0102, 32'hAABB_CCDD);
`ifdef MSRV_STORE_MISALIGN_SPLIT_EN
      chk_beat32("split.b0", 1'b1, 32'h100, 32'hCCDD_0000, 4'b1100);
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b1;
      tick();
      chk_beat32("split.b1", 1'b1, 32'h104, 32'h0000_AABB, 4'b0011);
      chk("split.b1_no_done", 64'(done32), 64'd0);
      tick();
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      chk("split.done", 64'(done32), 64'd1);
      chk("split.exc", 64'(exc32), 64'd0);
      tick();
      chk("split.done_end", 64'(done32), 64'd0);
      // Second beat address wraps past the top of the address space.
      issue32(3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
      chk_beat32("wrap.b0", 1'b1, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b1;
      tick();
      chk_beat32("wrap.b1", 1'b1, 32'h0000_0000, 32'h0000_1122, 4'b0011);
      tick();
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      chk("wrap.done", 64'(done32), 64'd1);
      tick();
`else
      chk("misal.req", 64'(bus32.ms_riscv32_mp_dmwr_req_out), 64'd0);
      chk("misal.exc", 64'(exc32), 64'd1);
      chk("misal.done", 64'(done32), 64'd0);
      tick();
      chk("misal.exc_end", 64'(exc32), 64'd0);
      chk("misal.ready", 64'(rdy32), 64'd1);
      chk("misal.req_after", 64'(bus32.ms_riscv32_mp_dmwr_req_out), 64'd0);
`endif

      // SD on a 32-bit instance is illegal.
      issue32(3'b011, 32'h0000_0008, 32'h0506_0708);
      chk("sd32.req", 64'(bus32.ms_riscv32_mp_dmwr_req_out), 64'd0);
      chk("sd32.exc", 64'(exc32), 64'd1);
      chk("sd32.done", 64'(done32), 64'd0);
      tick();
      chk("sd32.ready", 64'(rdy32), 64'd1);

      // SD on the 64-bit instance: full mask, data unshifted.
      f3_64 = 3'b011;
      a64   = 64'h8;
      d64   = 64'h0102_0304_0506_0708;
      v64   = 1'b1;
      tick();
      v64   = 1'b0;
      chk("sd64.req", 64'(bus64.ms_riscv32_mp_dmwr_req_out), 64'd1);
      chk("sd64.addr", bus64.ms_riscv32_mp_dmaddr_out, 64'h8);
      chk("sd64.data", bus64.ms_riscv32_mp_dmdata_out, 64'h0102_0304_0506_0708);
      chk("sd64.mask", 64'(bus64.ms_riscv32_mp_dmwr_mask_out), 64'hFF);
      bus64.ms_riscv32_mp_dmwr_ack_in = 1'b1;
      tick();
      bus64.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      chk("sd64.done", 64'(done64), 64'd1);
      chk("sd64.exc", 64'(exc64), 64'd0);
      tick();

      // Reset mid-beat: request drops without a clock edge.
      issue32(3'b010, 32'h0000_0300, 32'hCAFE_F00D);
      chk("rst_mid.req_before", 64'(bus32.ms_riscv32_mp_dmwr_req_out), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_beat32("rst_mid", 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_mid.ready", 64'(rdy32), 64'd1);
      chk("rst_mid.no_done", 64'(done32), 64'd0);
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b1;
      tick();
      bus32.ms_riscv32_mp_dmwr_ack_in = 1'b0;
      chk("rst_mid.no_done_late", 64'(done32), 64'd0);
      chk("rst_mid.req_idle", 64'(bus32.ms_riscv32_mp_dmwr_req_out), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
